onehot_dwell_decoder: RTL and testbench
=======================================

// Module: onehot_dwell_decoder
// PURPOSE
//  - Inverse of the 8:3 channel encoder. Accepts a stream of binary channel codes over a valid/ready handshake.
//  - Drives the matching one-hot enable line for a programmable dwell time, then releases it.
//  - Sits between the channel scheduler (producer of codes) and the per-channel RF enable fan-out.
// PARAMETERS
//  - IN_W   default 3   width of binary code
//  - OUT_W  default 8   number of one-hot lines (OUT_W <= 2**IN_W)
//  - CNT_W  default 8   width of dwell counter / dwell input
// PORTS
//  - clk         in   1      single clock; all state updates on rising edge
//  - rst         in   1      synchronous, active-high reset
//  - in_valid    in   1      code/dwell valid
//  - in_ready    out  1      block can accept a code this cycle
//  - code        in   IN_W   binary channel index
//  - dwell       in   CNT_W  enable hold time in cycles, sampled on accept
//  - abort       in   1      drop current dwell immediately
//  - onehot      out  OUT_W  registered one-hot enable lines
//  - busy        out  1      high while in DWELL
//  - done        out  1      one-cycle pulse when a dwell completes normally
//  - range_err   out  1      one-cycle pulse, out-of-range code (see CONFIGURATION)
// BEHAVIOUR
//  - Accept = in_valid && in_ready at a rising edge.
//  - Reset (rst=1 at edge): state=IDLE; onehot=0, busy=0, done=0, range_err=0, counter=0. Reset overrides every other input.
//  - States:
//    - IDLE: in_ready=1 (unless abort), onehot=0.
//    - DWELL: onehot=1<<code_q; cnt counts down.
//  - IDLE -> DWELL on accept. Load cnt = (dwell==0) ? 1 : dwell and code_q = code.
//  - Latency: onehot reflects the new code the cycle after the accept edge. It is held exactly max(dwell,1) cycles.
//  - DWELL with cnt>1: cnt decrements by 1, in_ready=0.
//  - DWELL with cnt==1: in_ready=1 and done=1 on the following cycle.
//    - If an accept occurs, reload code_q/cnt and stay in DWELL (back-to-back, no zero gap on onehot).
//    - Otherwise go to IDLE; onehot=0 next cycle.
//  - abort=1 (any state): in_ready forced 0. Next cycle state=IDLE, onehot=0, busy=0, no done pulse. Abort wins over a simultaneous in_valid and over cnt==1.
//  - busy == (state==DWELL). At most one onehot bit is ever set.
//  - Counter never wraps: the decrement is gated at cnt==1. dwell=2**CNT_W-1 gives the maximum hold.
// CONFIGURATION
//  - Macro DECODER_RANGE_ERR_EN.
//  - When defined, a code >= OUT_W is consumed on accept and not dwelled: the state stays or returns to IDLE, onehot=0, and range_err pulses 1 cycle.
//  - When undefined, such a code dwells normally with onehot=0 for the dwell period, and range_err is tied 0.
//  - With OUT_W==2**IN_W the macro has no observable effect.
// STRUCTURE
//  - Package onehot_dwell_decoder_pkg: state enum {IDLE, DWELL}, default widths, function max1(dwell).
//  - Sub-module onehot_decode: combinational code->OUT_W one-hot with in-range flag. Reused by the fan-out block.
//  - Top: FSM, dwell counter, output register.
// TESTING
//  - Reset, then code=5, dwell=3 accepted -> onehot=8'h20 for exactly 3 cycles, done pulse, then onehot=0, busy=0.
//  - Back-to-back: code=1 dwell=2, then code=6 dwell=1 presented at cnt==1 -> onehot 8'h02,8'h02,8'h40, no zero gap.
//  - dwell=0 with code=0 -> onehot=8'h01 for 1 cycle, done pulse.
//  - abort in 2nd cycle of dwell=10 with in_valid=1 -> onehot=0 next cycle, no done, in_ready=0 during abort.
//  - rst asserted mid-dwell -> all outputs 0 next cycle. First code after release is decoded normally.
//  - OUT_W=6, code=7: macro on -> range_err pulse, onehot stays 0, busy=0. Macro off -> busy high for dwell cycles, onehot=0.

Source files
------------

// File: rtl/onehot_dwell_decoder_pkg.sv
// Shared types and helpers for the one-hot dwell decoder.
//   state_e   : FSM state encoding (StIdle, StDwell)
//   Def*W     : default code, one-hot and dwell-counter widths
//   max1()    : dwell value with zero promoted to one (minimum hold of one cycle)
package onehot_dwell_decoder_pkg;

  localparam int unsigned DefInW  = 3;
  localparam int unsigned DefOutW = 8;
  localparam int unsigned DefCntW = 8;

  typedef enum logic {
    StIdle  = 1'b0,
    StDwell = 1'b1
  } state_e;

  // Callers with dwell counters wider than 32 bits must not rely on this helper.
  function automatic int unsigned max1(input int unsigned dwell);
    return (dwell == 0) ? 32'd1 : dwell;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational binary-to-one-hot decoder with an in-range flag.
// Also used by the per-channel fan-out block.
// Ports:
//   code_i     : binary channel index
//   onehot_o   : one-hot line for code_i, all zero when code_i >= OUT_W
//   in_range_o : high when code_i < OUT_W
module onehot_decode #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  code_i,
  output logic [OUT_W-1:0] onehot_o,
  output logic             in_range_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (32'(code_i) == i) begin
        onehot_o[i] = 1'b1;
      end
    end
    in_range_o = (32'(code_i) < OUT_W);
  end

endmodule

// File: rtl/onehot_dwell_decoder.sv
// One-hot dwell decoder: accepts binary channel codes over valid/ready and drives the
// matching one-hot enable line for max(dwell,1) cycles, then releases it. A code offered
// during the last dwell cycle is taken back-to-back with no gap on the enable lines.
// Optional feature: define DECODER_RANGE_ERR_EN to reject codes >= OUT_W (consumed, not
// dwelled, range_err_o pulses). Without it such codes dwell with all lines low.
// Ports:
//   clk_i        : clock, all state on rising edge
//   rst_i        : synchronous active-high reset
//   in_valid_i   : code/dwell valid
//   in_ready_o   : block can accept a code this cycle
//   code_i       : binary channel index
//   dwell_i      : hold time in cycles, sampled on accept (0 behaves as 1)
//   abort_i      : drop the current dwell, blocks acceptance this cycle
//   onehot_o     : registered one-hot enable lines
//   busy_o       : high while dwelling
//   done_o       : one-cycle pulse after a dwell completes normally
//   range_err_o  : one-cycle pulse on an accepted out-of-range code (feature builds only)
module onehot_dwell_decoder
  import onehot_dwell_decoder_pkg::*;
#(
  parameter int unsigned IN_W  = DefInW,
  parameter int unsigned OUT_W = DefOutW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  code_i,
  input  logic [CNT_W-1:0] dwell_i,
  input  logic             abort_i,
  output logic [OUT_W-1:0] onehot_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             range_err_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  code_q, code_d;
  logic [OUT_W-1:0] onehot_q, onehot_d;
  logic             done_q, done_d;
  logic             range_err_q, range_err_d;

  logic [OUT_W-1:0] dec_onehot;
  logic             dec_in_range;
  logic             last_cycle;
  logic             accept;
  logic             code_ok;

  // cnt_q holds the remaining hold cycles including the current one.
  assign last_cycle = (state_q == StDwell) && (cnt_q == CNT_W'(1));
  assign in_ready_o = !abort_i && ((state_q == StIdle) || last_cycle);
  assign accept     = in_valid_i && in_ready_o;
  assign code_d     = accept ? code_i : code_q;

  // Decoding the next code lets the output register load the new line on the accept edge.
  onehot_decode #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_decode (
    .code_i     (code_d),
    .onehot_o   (dec_onehot),
    .in_range_o (dec_in_range)
  );

`ifdef DECODER_RANGE_ERR_EN
  assign code_ok = dec_in_range;
`else
  logic unused_in_range;
  assign unused_in_range = dec_in_range;
  assign code_ok         = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    range_err_d = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      // A dwell finishing this cycle completes normally even if a new code is taken.
      done_d = last_cycle;
      if (accept) begin
        if (code_ok) begin
          state_d = StDwell;
          cnt_d   = CNT_W'(max1(32'(dwell_i)));
        end else begin
          state_d     = StIdle;
          cnt_d       = '0;
          range_err_d = 1'b1;
        end
      end else if (state_q == StDwell) begin
        if (last_cycle) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          // Never reaches zero here, so the counter cannot wrap.
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
    onehot_d = (state_d == StDwell) ? dec_onehot : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      code_q      <= '0;
      onehot_q    <= '0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      onehot_q    <= onehot_d;
      done_q      <= done_d;
      range_err_q <= range_err_d;
    end
  end

  assign onehot_o    = onehot_q;
  assign busy_o      = (state_q == StDwell);
  assign done_o      = done_q;
  assign range_err_o = range_err_q;

endmodule

// File: tb/tb_onehot_dwell_decoder.sv
module tb_onehot_dwell_decoder;

`ifdef DECODER_RANGE_ERR_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] code = '0;
  logic [7:0] dwell = '0;

  logic       rdy8, busy8, done8, rerr8;
  logic [7:0] oh8;
  logic       rdy6, busy6, done6, rerr6;
  logic [5:0] oh6;

  int total = 0;
  int bad   = 0;

  // Model state per instance: index 0 is OUT_W=8, index 1 is OUT_W=6.
  int m_rem  [2];
  int m_code [2];
  int m_oh   [2];
  bit m_done [2];
  bit m_rerr [2];

  always #5 clk = ~clk;

  onehot_dwell_decoder u_dut8 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (rdy8),
    .code_i      (code),
    .dwell_i     (dwell),
    .abort_i     (abort),
    .onehot_o    (oh8),
    .busy_o      (busy8),
    .done_o      (done8),
    .range_err_o (rerr8)
  );

  onehot_dwell_decoder #(
    .IN_W  (3),
    .OUT_W (6),
    .CNT_W (8)
  ) u_dut6 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (rdy6),
    .code_i      (code),
    .dwell_i     (dwell),
    .abort_i     (abort),
    .onehot_o    (oh6),
    .busy_o      (busy6),
    .done_o      (done6),
    .range_err_o (rerr6)
  );

  function automatic int out_w(input int i);
    return (i == 0) ? 8 : 6;
  endfunction

  function automatic bit m_ready(input int i);
    return !abort && (m_rem[i] <= 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-edge model: m_rem counts the onehot cycles still to come, m_code is the dwelled code.
  task automatic step_model(input int i);
    bit acc;
    int d;
    if (rst || abort) begin
      m_rem[i]  = 0;
      m_done[i] = 1'b0;
      m_rerr[i] = 1'b0;
    end else begin
      acc       = in_valid && (m_rem[i] <= 1);
      m_done[i] = (m_rem[i] == 1);
      m_rerr[i] = 1'b0;
      if (acc) begin
        d = (dwell == 0) ? 1 : int'(dwell);
        if (RangeEn && int'(code) >= out_w(i)) begin
          m_rem[i]  = 0;
          m_rerr[i] = 1'b1;
        end else begin
          m_rem[i]  = d;
          m_code[i] = int'(code);
        end
      end else if (m_rem[i] > 0) begin
        m_rem[i] = m_rem[i] - 1;
      end
    end
    m_oh[i] = (m_rem[i] > 0 && m_code[i] < out_w(i)) ? (1 << m_code[i]) : 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_code[i] = 0; m_oh[i] = 0; m_done[i] = 0; m_rerr[i] = 0;
    end
    forever begin
      @(posedge clk);
      step_model(0);
      step_model(1);
    end
  end

  // Compare process: outputs settled from the last edge, inputs set for the next one.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("ready8", int'(rdy8), int'(m_ready(0)));
      chk("onehot8", int'(oh8), m_oh[0]);
      chk("busy8", int'(busy8), int'(m_rem[0] > 0));
      chk("done8", int'(done8), int'(m_done[0]));
      chk("rerr8", int'(rerr8), int'(m_rerr[0]));
      chk("ready6", int'(rdy6), int'(m_ready(1)));
      chk("onehot6", int'(oh6), m_oh[1]);
      chk("busy6", int'(busy6), int'(m_rem[1] > 0));
      chk("done6", int'(done6), int'(m_done[1]));
      chk("rerr6", int'(rerr6), int'(m_rerr[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input bit v, input int c, input int d);
    in_valid = v;
    code     = 3'(c);
    dwell    = 8'(d);
  endtask

  initial begin
    tick();
    tick();
    chk("pin_reset_busy", int'(m_rem[0] > 0), 0);
    chk("pin_reset_oh", m_oh[0], 0);
    rst = 1'b0;

    // code 5, dwell 3
    offer(1, 5, 3); tick(); offer(0, 0, 0);
    chk("pin_c5_oh1", m_oh[0], 8'h20);
    tick(); chk("pin_c5_oh2", m_oh[0], 8'h20);
    tick(); chk("pin_c5_oh3", m_oh[0], 8'h20);
    tick(); chk("pin_c5_off", m_oh[0], 0); chk("pin_c5_done", int'(m_done[0]), 1);
    tick(); chk("pin_c5_idle", int'(m_rem[0] > 0), 0); chk("pin_c5_done0", int'(m_done[0]), 0);

    // back-to-back: code 1 dwell 2, then code 6 dwell 1 at the last cycle
    offer(1, 1, 2); tick(); offer(0, 0, 0);
    chk("pin_b2b_a", m_oh[0], 8'h02);
    tick(); chk("pin_b2b_b", m_oh[0], 8'h02);
    offer(1, 6, 1); tick(); offer(0, 0, 0);
    chk("pin_b2b_c", m_oh[0], 8'h40);
    tick(); chk("pin_b2b_off", m_oh[0], 0);

    // dwell 0 behaves as 1
    offer(1, 0, 0); tick(); offer(0, 0, 0);
    chk("pin_d0_oh", m_oh[0], 8'h01);
    tick(); chk("pin_d0_off", m_oh[0], 0); chk("pin_d0_done", int'(m_done[0]), 1);

    // abort in the 2nd dwell cycle with a competing valid
    offer(1, 3, 10); tick(); offer(0, 0, 0);
    tick();
    abort = 1'b1; offer(1, 2, 4);
    chk("pin_abort_ready", int'(m_ready(0)), 0);
    tick(); abort = 1'b0; offer(0, 0, 0);
    chk("pin_abort_oh", m_oh[0], 0);
    chk("pin_abort_done", int'(m_done[0]), 0);
    tick();

    // reset mid-dwell, then a normal code
    offer(1, 4, 5); tick(); offer(0, 0, 0);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    chk("pin_rst_oh", m_oh[0], 0);
    offer(1, 2, 1); tick(); offer(0, 0, 0);
    chk("pin_rst_next", m_oh[0], 8'h04);
    tick();

    // out-of-range code on the 6-line instance
    offer(1, 7, 3); tick(); offer(0, 0, 0);
    chk("pin_oor_oh", m_oh[1], 0);
    chk("pin_oor_busy", int'(m_rem[1] > 0), RangeEn ? 0 : 1);
    chk("pin_oor_rerr", int'(m_rerr[1]), RangeEn ? 1 : 0);
    repeat (4) tick();

    // maximum dwell holds 255 cycles
    offer(1, 2, 255); tick(); offer(0, 0, 0);
    repeat (254) tick();
    chk("pin_max_hold", m_oh[0], 8'h04);
    tick(); chk("pin_max_off", m_oh[0], 0); chk("pin_max_done", int'(m_done[0]), 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      code     = 3'($urandom_range(0, 7));
      dwell    = ($urandom_range(0, 31) == 0) ? 8'd255 : 8'($urandom_range(0, 5));
      abort    = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      tick();
    end
    offer(0, 0, 0); abort = 1'b0; rst = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
